// File: rtl/arb_pkg.sv
// Shared constants and types for the 4-port arbiter slice.
package arb_pkg;

  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_4x_nbit.sv
// 4-to-1 N-bit multiplexer; also used downstream to steer sideband buses by sel.
module mux_4x_nbit
  import arb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic [BUS_WIDTH-1:0] d0,
  input  logic [BUS_WIDTH-1:0] d1,
  input  logic [BUS_WIDTH-1:0] d2,
  input  logic [BUS_WIDTH-1:0] d3,
  input  sel_t                 sel,
  output logic [BUS_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick_4.sv
// Combinational 4-way grant picker; round-robin from ptr, or fixed priority
// (port 0 highest) when ARB_FIXED_PRIO_EN is defined.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  sel_t                 ptr,
  output logic                 gnt_vld,
  output sel_t                 gnt_idx
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = sel_t'(k);
      end
    end
  end
`else
  sel_t idx;

  // Scan from the farthest offset down so the port nearest ptr wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    idx     = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = ptr + sel_t'(k);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end
`endif

endmodule

// File: rtl/rr_arb_4x_nbit.sv
// 4-port round-robin arbiter with a one-entry registered output and exported grant index.
// Define ARB_FIXED_PRIO_EN for fixed priority (port 0 highest, no pointer).
module rr_arb_4x_nbit
  import arb_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           in_valid,
  input  logic [BUS_WIDTH-1:0] in_data0,
  input  logic [BUS_WIDTH-1:0] in_data1,
  input  logic [BUS_WIDTH-1:0] in_data2,
  input  logic [BUS_WIDTH-1:0] in_data3,
  output logic [3:0]           in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [1:0]           sel
);

  logic                 load;
  logic                 gnt_vld;
  sel_t                 gnt_idx;
  sel_t                 ptr_q;
  logic [BUS_WIDTH-1:0] gnt_data;
  logic                 out_valid_q;
  logic [BUS_WIDTH-1:0] out_data_q;
  sel_t                 sel_q;

  // Slot is free, or its word leaves this cycle.
  assign load = ~out_valid_q | out_ready;

  rr_pick_4 u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  mux_4x_nbit #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_mux (
    .d0  (in_data0),
    .d1  (in_data1),
    .d2  (in_data2),
    .d3  (in_data3),
    .sel (gnt_idx),
    .y   (gnt_data)
  );

  always_comb begin
    in_ready = '0;
    if (load && gnt_vld) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sel_q       <= '0;
    end else if (load) begin
      if (gnt_vld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= gnt_data;
        sel_q       <= gnt_idx;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign ptr_q = '0;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (load && gnt_vld) begin
      ptr_q <= gnt_idx + sel_t'(1);
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_rr_arb_4x_nbit.sv
// Self-checking bench for rr_arb_4x_nbit: behavioural model plus directed literal checks.
module tb_rr_arb_4x_nbit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] in_valid = '0;
  logic [7:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic [1:0] sel;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  rr_arb_4x_nbit #(.BUS_WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data0  (in_data0),
    .in_data1  (in_data1),
    .in_data2  (in_data2),
    .in_data3  (in_data3),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  // Model state: one output slot and the port that gets first look next.
  bit       m_valid = 1'b0;
  bit [7:0] m_data = '0;
  int       m_sel = 0;
  int       m_ptr = 0;

  function automatic int winner(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [7:0] data_of(int g);
    case (g)
      0: return in_data0;
      1: return in_data1;
      2: return in_data2;
      default: return in_data3;
    endcase
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    g = winner(in_valid, m_ptr);
    if ((!m_valid || out_ready) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      m_ptr   <= 0;
    end else if (!m_valid || out_ready) begin
      g = winner(in_valid, m_ptr);
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= data_of(g);
        m_sel   <= g;
`ifdef ARB_FIXED_PRIO_EN
        m_ptr   <= 0;
`else
        m_ptr   <= (g + 1) % 4;
`endif
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("sel", 32'(sel), 32'(m_sel));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] v, logic r);
    in_valid  = v;
    out_ready = r;
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    step();
    started = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step();

`ifndef ARB_FIXED_PRIO_EN
    // Single request from port 1
    in_data1 = 8'hA5;
    in_valid = 4'b0010;
    #1 chk("p1_in_ready", 32'(in_ready), 32'b0010);
    drive(4'b0010, 1'b1);
    chk("p1_valid", 32'(out_valid), 32'd1);
    chk("p1_sel", 32'(sel), 32'd1);
    chk("p1_data", 32'(out_data), 32'hA5);
    chk("p1_model_ptr", 32'(m_ptr), 32'd2);
    drive(4'b0000, 1'b1);
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_data_hold", 32'(out_data), 32'hA5);

    // All ports requesting: rotation starts at ptr=2
    in_data0 = 8'h10; in_data1 = 8'h11; in_data2 = 8'h12; in_data3 = 8'h13;
    begin
      int exp_seq [5] = '{2, 3, 0, 1, 2};
      for (int i = 0; i < 5; i++) begin
        drive(4'b1111, 1'b1);
        chk("rr_valid", 32'(out_valid), 32'd1);
        chk("rr_sel", 32'(sel), 32'(exp_seq[i]));
        chk("rr_data", 32'(out_data), 32'(8'h10 + exp_seq[i]));
      end
    end

    // Port 3 granted, then stalled with ports 0 and 2 waiting
    in_data3 = 8'h3C;
    drive(4'b1000, 1'b1);
    chk("p3_sel", 32'(sel), 32'd3);
    in_data0 = 8'hC0; in_data2 = 8'hC2;
    for (int i = 0; i < 5; i++) begin
      in_valid = 4'b0101;
      out_ready = 1'b0;
      #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("stall_data", 32'(out_data), 32'h3C);
      chk("stall_sel", 32'(sel), 32'd3);
      chk("stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 chk("wrap_in_ready", 32'(in_ready), 32'b0001);
    step();
    chk("wrap_sel", 32'(sel), 32'd0);
    chk("wrap_data", 32'(out_data), 32'hC0);

    // Same-cycle drain and refill
    in_data2 = 8'h77;
    drive(4'b0100, 1'b1);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_sel", 32'(sel), 32'd2);
    chk("b2b_data", 32'(out_data), 32'h77);

    // Asynchronous reset mid-stream
    drive(4'b1111, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    step();
    rst_n = 1'b1;
    drive(4'b1100, 1'b1);
    chk("post_rst_sel", 32'(sel), 32'd2);
    drive(4'b1100, 1'b1);
    chk("post_rst_sel2", 32'(sel), 32'd3);
`else
    // Fixed priority: port 0 always wins over port 3
    in_data0 = 8'hA0; in_data3 = 8'hA3;
    for (int i = 0; i < 6; i++) begin
      in_valid = 4'b1001;
      out_ready = 1'b1;
      #1 chk("fp_in_ready", 32'(in_ready), 32'b0001);
      step();
      chk("fp_sel", 32'(sel), 32'd0);
      chk("fp_data", 32'(out_data), 32'hA0);
    end
`endif

    drive(4'b0000, 1'b1);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
